// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among N_REQ renderers.
// Define SPRITE_ARB_PRIO0_EN to give requester 0 fixed absolute priority.
module sprite_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 3,
   parameter int ROM_LAT = 0
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   output logic [N_REQ-1:0]          gnt,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_q,
   output logic [N_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int NS    = ROM_LAT + 1;
`ifdef SPRITE_ARB_PRIO0_EN
   localparam int BASE  = 1;
`else
   localparam int BASE  = 0;
`endif
   localparam int M     = N_REQ - BASE;

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  ptr_nxt;
   logic [IDX_W-1:0]  rptr;
   logic [M-1:0]      ring;
   logic              found;
   logic [IDX_W-1:0]  sel;
   logic              any_gnt;
   logic              prio_hit;
   logic [IDX_W-1:0]  gnt_idx;

   logic [ADDR_W-1:0] addr_a [N_REQ];
   logic [NS-1:0]     tag_v;
   logic [IDX_W-1:0]  tag_i [NS];

   for (genvar g = 0; g < N_REQ; g++) begin : g_addr
      assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
   end

   // Two passes: first at or above the pointer, then wrap from the bottom.
   always_comb begin
      ring  = req[N_REQ-1:BASE];
      rptr  = ptr - IDX_W'(BASE);
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < M; k++) begin
         if (!found && ring[k] && IDX_W'(k) >= rptr) begin
            found = 1'b1;
            sel   = IDX_W'(k);
         end
      end
      for (int k = 0; k < M; k++) begin
         if (!found && ring[k]) begin
            found = 1'b1;
            sel   = IDX_W'(k);
         end
      end
   end

   always_comb begin
`ifdef SPRITE_ARB_PRIO0_EN
      prio_hit = req[0];
`else
      prio_hit = 1'b0;
`endif
      any_gnt = prio_hit | found;
      gnt_idx = prio_hit ? '0 : sel + IDX_W'(BASE);
      gnt     = any_gnt ? N_REQ'(1) << gnt_idx : '0;
   end

   always_comb begin
      ptr_nxt = ptr;
      if (found && !prio_hit) begin
         if (gnt_idx == IDX_W'(N_REQ-1))
            ptr_nxt = IDX_W'(BASE);
         else
            ptr_nxt = gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr      <= IDX_W'(BASE);
         rom_addr <= '0;
      end else begin
         ptr <= ptr_nxt;
         if (any_gnt)
            rom_addr <= addr_a[gnt_idx];
      end
   end

   // Grant tags travel alongside the ROM read so responses return in order.
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_v <= '0;
         for (int s = 0; s < NS; s++)
            tag_i[s] <= '0;
      end else begin
         tag_v[0] <= any_gnt;
         tag_i[0] <= gnt_idx;
         for (int s = 1; s < NS; s++) begin
            tag_v[s] <= tag_v[s-1];
            tag_i[s] <= tag_i[s-1];
         end
      end
   end

   always_comb begin
      rsp_valid = tag_v[NS-1] ? N_REQ'(1) << tag_i[NS-1] : '0;
      rsp_data  = tag_v[NS-1] ? rom_q : '0;
      busy      = |tag_v;
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter at default parameters (ROM_LAT = 0).
// ROM model reads on negedge; content is addr[6:4] ^ addr[2:0].
module tb_sprite_rom_arbiter;

   logic        vga_clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [11:0] a [4];
   logic [47:0] req_addr;
   logic [3:0]  gnt;
   logic [11:0] rom_addr;
   logic [2:0]  rom_q = '0;
   logic [3:0]  rsp_valid;
   logic [2:0]  rsp_data;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;

   assign req_addr = {a[3], a[2], a[1], a[0]};

   always #5 vga_clk = ~vga_clk;

   always @(negedge vga_clk)
      rom_q <= rom_addr[6:4] ^ rom_addr[2:0];

   sprite_rom_arbiter dut (
      .vga_clk   (vga_clk),
      .reset_n   (reset_n),
      .req       (req),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_q     (rom_q),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after posedge; outputs sampled 1 ns after negedge.
   task automatic step(input logic rn, input logic [3:0] r);
      @(posedge vga_clk);
      #1;
      reset_n = rn;
      req     = r;
      @(negedge vga_clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic [3:0] v,
                          input logic [2:0] d);
      check({tag, "_rv"}, 16'(rsp_valid), 16'(v));
      check({tag, "_rd"}, 16'(rsp_data), 16'(d));
   endtask

`ifndef SPRITE_ARB_PRIO0_EN
   logic [3:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [2:0] exp_d [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                             3'd1, 3'd2, 3'd3, 3'd4};
   logic [11:0] exp_a [8] = '{12'h000, 12'h010, 12'h020, 12'h030,
                              12'h040, 12'h010, 12'h020, 12'h030};
`endif

   initial begin
      reset_n = 1'b0;
      req     = 4'b1111;
      a[0] = 12'h010;
      a[1] = 12'h020;
      a[2] = 12'h030;
      a[3] = 12'h040;

      step(1'b0, 4'b1111);
      step(1'b0, 4'b1111);
      check("rst_addr", 16'(rom_addr), 16'h000);
      chk_rsp("rst", 4'b0000, 3'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_gnt", 16'(gnt), 16'b0001);

`ifndef SPRITE_ARB_PRIO0_EN
      // Fairness: all four requesting, released this cycle.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 4'b1111);
         check($sformatf("fair_gnt%0d", k), 16'(gnt), 16'(exp_g[k]));
         check($sformatf("fair_addr%0d", k), 16'(rom_addr), 16'(exp_a[k]));
         if (k > 0) begin
            chk_rsp($sformatf("fair%0d", k), exp_g[k-1], exp_d[k-1]);
            check($sformatf("fair_busy%0d", k), 16'(busy), 16'd1);
         end
      end

      // Wrap after grant to 3.
      step(1'b1, 4'b1001);
      check("wrap_gnt0", 16'(gnt), 16'b0001);
      chk_rsp("wrap0", 4'b1000, 3'd4);
      step(1'b1, 4'b1001);
      check("wrap_gnt1", 16'(gnt), 16'b1000);
      chk_rsp("wrap1", 4'b0001, 3'd1);

      // Single requester 2 at 0x123.
      a[2] = 12'h123;
      step(1'b1, 4'b0100);
      check("single_gnt0", 16'(gnt), 16'b0100);
      check("single_addr0", 16'(rom_addr), 16'h040);
      chk_rsp("single0", 4'b1000, 3'd4);
      for (int k = 1; k < 3; k++) begin
         step(1'b1, 4'b0100);
         check($sformatf("single_gnt%0d", k), 16'(gnt), 16'b0100);
         check($sformatf("single_addr%0d", k), 16'(rom_addr), 16'h123);
         chk_rsp($sformatf("single%0d", k), 4'b0100, 3'd1);
      end
      step(1'b1, 4'b0000);
      check("drain_gnt", 16'(gnt), 16'b0000);
      chk_rsp("drain", 4'b0100, 3'd1);
      check("drain_busy", 16'(busy), 16'd1);
      step(1'b1, 4'b0000);
      chk_rsp("idle", 4'b0000, 3'd0);
      check("idle_busy", 16'(busy), 16'd0);
      check("idle_addr", 16'(rom_addr), 16'h123);

      // Reset mid-flight: ptr is 3, so requester 1 wins after wrap.
      step(1'b1, 4'b0010);
      check("mid_gnt", 16'(gnt), 16'b0010);
      step(1'b0, 4'b0000);
      chk_rsp("mid_rst", 4'b0000, 3'd0);
      check("mid_busy", 16'(busy), 16'd0);
      check("mid_addr", 16'(rom_addr), 16'h000);
      step(1'b1, 4'b0000);
      chk_rsp("post_rst0", 4'b0000, 3'd0);
      check("post_busy0", 16'(busy), 16'd0);
      step(1'b1, 4'b1010);
      check("post_gnt", 16'(gnt), 16'b0010);
      chk_rsp("post_rst1", 4'b0000, 3'd0);
      step(1'b1, 4'b0000);
      check("post_addr", 16'(rom_addr), 16'h020);
      chk_rsp("post_rsp", 4'b0010, 3'd2);
`else
      // Requester 0 holds absolute priority.
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 4'b0111);
         check($sformatf("prio_gnt%0d", k), 16'(gnt), 16'b0001);
         if (k > 0)
            chk_rsp($sformatf("prio%0d", k), 4'b0001, 3'd1);
      end
      step(1'b1, 4'b0110);
      check("rr_gnt0", 16'(gnt), 16'b0010);
      chk_rsp("rr0", 4'b0001, 3'd1);
      step(1'b1, 4'b0110);
      check("rr_gnt1", 16'(gnt), 16'b0100);
      chk_rsp("rr1", 4'b0010, 3'd2);
      step(1'b1, 4'b0110);
      check("rr_gnt2", 16'(gnt), 16'b0010);
      chk_rsp("rr2", 4'b0100, 3'd3);
      step(1'b1, 4'b0000);
      check("rr_gnt3", 16'(gnt), 16'b0000);
      chk_rsp("rr3", 4'b0010, 3'd2);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
